mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_prio.sv | 45 ++++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBusy
    } state_e;

    typedef enum logic {
        OwnInstr,
        OwnData
    } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between instruction and data ports with a data-starvation limiter.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   en_i,
    input  logic   i_req_i,
    input  logic   d_req_i,
    output logic   valid_o,
    output owner_e grant_o
);

    localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] starve_q, starve_d;

    always_comb begin
        valid_o  = en_i & (i_req_i | d_req_i);
        grant_o  = (d_req_i && !(i_req_i && starve_q == CntMax)) ? OwnData : OwnInstr;
        starve_d = starve_q;
        if (valid_o) begin
            // Count only data grants that overtook a waiting instruction request.
            if (grant_o == OwnData && i_req_i) begin
                if (starve_q != CntMax) begin
                    starve_d = starve_q + CntW'(1);
                end
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single strobe/ready memory interface,
// with a BUSY timeout that completes the transaction with err_o.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_req_i,
    input  logic [AddrW-1:0] i_addr_i,
    output logic             i_done_o,
    output logic [DataW-1:0] i_rdata_o,
    input  logic             d_req_i,
    input  logic             d_we_i,
    input  logic [AddrW-1:0] d_addr_i,
    input  logic [DataW-1:0] d_wdata_i,
    output logic             d_done_o,
    output logic [DataW-1:0] d_rdata_o,
    output logic             err_o,
    output logic             mem_re_o,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    input  logic [DataW-1:0] mem_rdata_i,
    input  logic             mem_ready_i
);

    localparam int unsigned TmoW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             we_q, we_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [DataW-1:0] wdata_q, wdata_d;
    logic [DataW-1:0] rdata_q, rdata_d;
    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;
    logic             err_q, err_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;

    logic   i_req_m, d_req_m, hold, grant_en, grant_valid;
    owner_e grant;

    always_comb begin
        i_req_m  = i_req_i & ~i_done_q;
        d_req_m  = d_req_i & ~d_done_q;
        // A port still requesting in its own done cycle is re-arbitrated next cycle as a
        // fresh request, so a continuously held port keeps its normal priority.
        hold     = (i_done_q & i_req_i) | (d_done_q & d_req_i);
        grant_en = (state_q == StIdle) & ~hold;
    end

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (grant_en),
        .i_req_i(i_req_m),
        .d_req_i(d_req_m),
        .valid_o(grant_valid),
        .grant_o(grant)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = '0;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        err_d    = 1'b0;
        tmo_d    = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    owner_d = grant;
                    state_d = StIssue;
                    if (grant == OwnData) begin
                        we_d    = d_we_i;
                        addr_d  = d_addr_i;
                        wdata_d = d_wdata_i;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = i_addr_i;
                        wdata_d = '0;
                    end
                end
            end
            StIssue: begin
                state_d = StBusy;
                tmo_d   = '0;
            end
            StBusy: begin
                if (mem_ready_i || tmo_q == TmoLast) begin
                    state_d  = StIdle;
                    err_d    = ~mem_ready_i;
                    rdata_d  = mem_ready_i ? mem_rdata_i : '0;
                    i_done_d = (owner_q == OwnInstr);
                    d_done_d = (owner_q == OwnData);
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            owner_q  <= OwnInstr;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        mem_re_o    = (state_q == StIssue) & ~we_q;
        mem_we_o    = (state_q == StIssue) & we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        i_done_o    = i_done_q;
        d_done_o    = d_done_q;
        err_o       = err_q;
        i_rdata_o   = i_done_q ? rdata_q : '0;
        d_rdata_o   = d_done_q ? rdata_q : '0;
    end

endmodule
